// File: rtl/mojo_serial_tx_arbiter.sv
// mojo_serial_tx_arbiter
// Shares one serial UART transmitter between NUM_CH block producers. A pending
// requester is picked round-robin, its BLOCK_BYTES-wide block is latched, and an
// optional channel-tag header byte followed by the block bytes (byte 0 first) is
// handed to the UART one byte at a time, paced against tx_busy.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active-high
//   req          per-channel block pending
//   blocks       channel i block at [i*BLOCK_BYTES*8 +: BLOCK_BYTES*8]
//   ack          one-cycle pulse, channel block latched
//   busy         high from grant until the last byte is handed to the UART
//   grant_id     channel being sent (valid while busy)
//   tx_busy      UART busy; a byte is handed over only when low
//   tx_data      byte to UART
//   new_tx_data  one-cycle strobe qualifying tx_data
module mojo_serial_tx_arbiter #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned BLOCK_BYTES = 4,
    parameter bit          HEADER_EN   = 1'b1,
    parameter logic [3:0]  HEADER_TAG  = 4'hA
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CH-1:0]               req,
    input  logic [NUM_CH*BLOCK_BYTES*8-1:0] blocks,
    output logic [NUM_CH-1:0]               ack,
    output logic                            busy,
    output logic [3:0]                      grant_id,
    input  logic                            tx_busy,
    output logic [7:0]                      tx_data,
    output logic                            new_tx_data
);

    localparam int unsigned BW = BLOCK_BYTES * 8;
    localparam int unsigned CW = $clog2(BLOCK_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        HOLD
    } state_t;

    state_t          state_q, state_d;
    logic            hold_idle_q, hold_idle_d;
    logic [BW-1:0]   shift_q, shift_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      ptr_q, ptr_d;

    logic [7:0]        tx_data_d;
    logic              new_tx_data_d;
    logic [NUM_CH-1:0] ack_d;
    logic              busy_d;
    logic [3:0]        grant_id_d;

    logic              gnt_found;
    logic [3:0]        gnt_idx;
    logic [NUM_CH-1:0] gnt_oh;
    logic [BW-1:0]     gnt_block;

    // Round-robin pick: channels above the pointer first, then wrap to those at or below it.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 4'd0;
        gnt_oh    = '0;
        gnt_block = '0;
        for (int unsigned j = 0; j < NUM_CH; j++) begin
            if (!gnt_found && (j > 32'(ptr_q)) && req[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = 4'(j);
                gnt_oh[j] = 1'b1;
                gnt_block = blocks[j*BW +: BW];
            end
        end
        for (int unsigned j = 0; j < NUM_CH; j++) begin
            if (!gnt_found && (j <= 32'(ptr_q)) && req[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = 4'(j);
                gnt_oh[j] = 1'b1;
                gnt_block = blocks[j*BW +: BW];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_idle_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            ptr_q       <= 4'(NUM_CH - 1);
            tx_data     <= 8'd0;
            new_tx_data <= 1'b0;
            ack         <= '0;
            busy        <= 1'b0;
            grant_id    <= 4'd0;
        end else begin
            state_q     <= state_d;
            hold_idle_q <= hold_idle_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            tx_data     <= tx_data_d;
            new_tx_data <= new_tx_data_d;
            ack         <= ack_d;
            busy        <= busy_d;
            grant_id    <= grant_id_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        hold_idle_d   = hold_idle_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        tx_data_d     = tx_data;
        new_tx_data_d = 1'b0;
        ack_d         = '0;
        busy_d        = busy;
        grant_id_d    = grant_id;

        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    shift_d    = gnt_block;
                    ack_d      = gnt_oh;
                    busy_d     = 1'b1;
                    grant_id_d = gnt_idx;
                    ptr_d      = gnt_idx;
                    cnt_d      = CW'(BLOCK_BYTES);
                    state_d    = HEADER_EN ? HDR : DATA;
                end
            end
            HDR: begin
                if (!tx_busy) begin
                    tx_data_d     = {HEADER_TAG, grant_id};
                    new_tx_data_d = 1'b1;
                    hold_idle_d   = 1'b0;
                    state_d       = HOLD;
                end
            end
            DATA: begin
                if (!tx_busy) begin
                    tx_data_d     = shift_q[7:0];
                    new_tx_data_d = 1'b1;
                    shift_d       = shift_q >> 8;
                    cnt_d         = cnt_q - CW'(1);
                    state_d       = HOLD;
                    if (cnt_q > CW'(1)) begin
                        hold_idle_d = 1'b0;
                    end else begin
                        hold_idle_d = 1'b1;
                        busy_d      = 1'b0;
                    end
                end
            end
            HOLD: begin
                // UART raises tx_busy one cycle after a strobe; skip sampling it here.
                state_d = hold_idle_q ? IDLE : DATA;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mojo_serial_tx_arbiter.sv
// Testbench for mojo_serial_tx_arbiter: directed steps with a byte/grant scoreboard.
module tb_mojo_serial_tx_arbiter;

    logic         clk;
    logic         rst;
    int           cyc = 0;

    // DUT A: NUM_CH=4, BLOCK_BYTES=4, header enabled
    logic [3:0]   req_a = 4'b0;
    logic [127:0] blocks_a = '0;
    logic [3:0]   ack_a;
    logic         busy_a;
    logic [3:0]   grant_id_a;
    logic         tx_busy_a = 1'b0;
    logic [7:0]   tx_data_a;
    logic         new_tx_data_a;

    // DUT B: NUM_CH=4, BLOCK_BYTES=1, no header
    logic [3:0]   req_b = 4'b0;
    logic [31:0]  blocks_b = '0;
    logic [3:0]   ack_b;
    logic         busy_b;
    logic [3:0]   grant_id_b;
    logic         tx_busy_b = 1'b0;
    logic [7:0]   tx_data_b;
    logic         new_tx_data_b;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] exp_q_a[$];
    int         exp_gnt_a[$];
    logic [7:0] exp_q_b[$];
    int         exp_gnt_b[$];

    logic uart_en = 1'b0;
    int   busy_cnt = 0;
    logic fall_valid = 1'b0;
    int   fall_cyc = 0;
    logic prev_strobe_a = 1'b0;
    logic prev_txb_a = 1'b0;
    logic prev_strobe_b = 1'b0;

    mojo_serial_tx_arbiter #(
        .NUM_CH(4), .BLOCK_BYTES(4), .HEADER_EN(1'b1), .HEADER_TAG(4'hA)
    ) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .blocks(blocks_a), .ack(ack_a),
        .busy(busy_a), .grant_id(grant_id_a), .tx_busy(tx_busy_a),
        .tx_data(tx_data_a), .new_tx_data(new_tx_data_a)
    );

    mojo_serial_tx_arbiter #(
        .NUM_CH(4), .BLOCK_BYTES(1), .HEADER_EN(1'b0), .HEADER_TAG(4'hA)
    ) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .blocks(blocks_b), .ack(ack_b),
        .busy(busy_b), .grant_id(grant_id_b), .tx_busy(tx_busy_b),
        .tx_data(tx_data_b), .new_tx_data(new_tx_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] blk_val(input int ch);
        logic [31:0] v;
        for (int b = 0; b < 4; b++) v[b*8 +: 8] = 8'((ch + 1) * 16 + b + 1);
        return v;
    endfunction

    task automatic set_block_a(input int ch, input logic [31:0] v);
        blocks_a[ch*32 +: 32] = v;
    endtask

    task automatic push_block_a(input int g, input logic [31:0] v);
        exp_gnt_a.push_back(g);
        exp_q_a.push_back({4'hA, 4'(g)});
        for (int b = 0; b < 4; b++) exp_q_a.push_back(v[b*8 +: 8]);
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_new_tx_data"}, 32'(new_tx_data_a), 0);
        check({tag, "_tx_data"}, 32'(tx_data_a), 0);
        check({tag, "_ack"}, 32'(ack_a), 0);
        check({tag, "_busy"}, 32'(busy_a), 0);
        check({tag, "_grant_id"}, 32'(grant_id_a), 0);
    endtask

    task automatic wait_ack_a(input string tag, input int limit);
        int n;
        n = 0;
        while (ack_a === 4'b0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ack_timeout"}, 32'(n < limit), 1);
        req_a = 4'b0;
    endtask

    task automatic drain_a(input string tag, input int limit);
        int n;
        n = 0;
        while ((exp_q_a.size() != 0 || exp_gnt_a.size() != 0 || busy_a !== 1'b0 ||
                tx_busy_a !== 1'b0) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_drain_timeout"}, 32'(n < limit), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Scoreboard and UART model for DUT A.
    always @(negedge clk) begin
        int g;
        if (ack_a !== 4'b0) begin
            if (exp_gnt_a.size() == 0) begin
                check("ack_unexpected_a", 32'(ack_a), 0);
            end else begin
                g = exp_gnt_a.pop_front();
                check("ack_a", 32'(ack_a), 32'(1) << g);
                check("grant_id_a", 32'(grant_id_a), 32'(g));
                check("busy_at_ack_a", 32'(busy_a), 1);
            end
        end
        if (new_tx_data_a === 1'b1) begin
            check("strobe_gap_a", 32'(prev_strobe_a), 0);
            check("strobe_while_busy_a", 32'(prev_txb_a), 0);
            if (uart_en && fall_valid) check("resume_latency_a", 32'(cyc), 32'(fall_cyc + 1));
            if (exp_q_a.size() == 0) check("strobe_unexpected_a", 32'(new_tx_data_a), 0);
            else check("byte_a", 32'(tx_data_a), 32'(exp_q_a.pop_front()));
        end
        if (uart_en) begin
            if (new_tx_data_a === 1'b1) begin
                tx_busy_a  = 1'b1;
                busy_cnt   = 10;
                fall_valid = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    tx_busy_a  = 1'b0;
                    fall_valid = 1'b1;
                    fall_cyc   = cyc;
                end
            end
        end else begin
            tx_busy_a  = 1'b0;
            busy_cnt   = 0;
            fall_valid = 1'b0;
        end
        prev_strobe_a = new_tx_data_a;
        prev_txb_a    = tx_busy_a;
    end

    // Scoreboard for DUT B.
    always @(negedge clk) begin
        int g;
        if (ack_b !== 4'b0) begin
            if (exp_gnt_b.size() == 0) begin
                check("ack_unexpected_b", 32'(ack_b), 0);
            end else begin
                g = exp_gnt_b.pop_front();
                check("ack_b", 32'(ack_b), 32'(1) << g);
                check("grant_id_b", 32'(grant_id_b), 32'(g));
            end
        end
        if (new_tx_data_b === 1'b1) begin
            check("strobe_gap_b", 32'(prev_strobe_b), 0);
            if (exp_q_b.size() == 0) check("strobe_unexpected_b", 32'(new_tx_data_b), 0);
            else check("byte_b", 32'(tx_data_b), 32'(exp_q_b.pop_front()));
        end
        prev_strobe_b = new_tx_data_b;
    end

    initial begin
        int acks;
        int n;
        int ns;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero_a("reset_a");
        check("reset_b_busy", 32'(busy_b), 0);
        check("reset_b_new_tx_data", 32'(new_tx_data_b), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: single block on channel 0, cycle-exact latency
        set_block_a(0, 32'h44332211);
        push_block_a(0, 32'h44332211);
        req_a = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            check($sformatf("t1_ack_c%0d", k), 32'(ack_a), (k == 1) ? 32'h1 : 32'h0);
            check($sformatf("t1_strobe_c%0d", k), 32'(new_tx_data_a),
                  (k >= 2 && k <= 10 && (k % 2) == 0) ? 32'h1 : 32'h0);
            check($sformatf("t1_busy_c%0d", k), 32'(busy_a), (k <= 9) ? 32'h1 : 32'h0);
            if (k == 1) req_a = 4'b0;
        end
        check("t1_queue_empty", 32'(exp_q_a.size()), 0);

        // Reset so round-robin restarts at channel 0
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero_a("reset2_a");
        rst = 1'b0;
        @(posedge clk); #1;

        // 2: all channels requesting continuously, round-robin order
        for (int i = 0; i < 4; i++) set_block_a(i, blk_val(i));
        push_block_a(0, blk_val(0));
        push_block_a(1, blk_val(1));
        push_block_a(2, blk_val(2));
        push_block_a(3, blk_val(3));
        push_block_a(0, blk_val(0));
        push_block_a(1, blk_val(1));
        req_a = 4'b1111;
        acks = 0;
        n = 0;
        while (acks < 6 && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (ack_a !== 4'b0) acks++;
        end
        req_a = 4'b0;
        check("t2_grant_count", 32'(acks), 6);
        drain_a("t2", 200);

        // 3: UART holds tx_busy 10 cycles after each strobe
        uart_en = 1'b1;
        set_block_a(2, 32'hDDCCBBAA);
        push_block_a(2, 32'hDDCCBBAA);
        req_a = 4'b0100;
        wait_ack_a("t3", 20);
        drain_a("t3", 300);
        uart_en = 1'b0;
        @(posedge clk); #1;

        // 4: no header, one-byte blocks
        blocks_b[16 +: 8] = 8'h5A;
        exp_gnt_b.push_back(2);
        exp_q_b.push_back(8'h5A);
        req_b = 4'b0100;
        n = 0;
        while (ack_b === 4'b0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("t4_ack_timeout", 32'(n < 20), 1);
        check("t4_grant_id", 32'(grant_id_b), 2);
        req_b = 4'b0;
        @(posedge clk); #1;
        check("t4_strobe", 32'(new_tx_data_b), 1);
        check("t4_tx_data", 32'(tx_data_b), 32'h5A);
        check("t4_busy_cleared", 32'(busy_b), 0);
        repeat (4) @(posedge clk);
        #1;
        check("t4_queue_empty", 32'(exp_q_b.size() + exp_gnt_b.size()), 0);

        // 5: reset after the second data byte aborts the block
        set_block_a(0, 32'h44332211);
        exp_gnt_a.push_back(0);
        exp_q_a.push_back(8'hA0);
        exp_q_a.push_back(8'h11);
        exp_q_a.push_back(8'h22);
        req_a = 4'b0001;
        ns = 0;
        n = 0;
        while (ns < 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (ack_a[0] === 1'b1) req_a = 4'b0;
            if (new_tx_data_a === 1'b1) ns++;
        end
        check("t5_strobe_timeout", 32'(ns), 3);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero_a("t5_after_rst");
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("t5_no_more_strobes", 32'(exp_q_a.size()), 0);
        check("t5_idle_busy", 32'(busy_a), 0);
        // Channel 0 must win after reset even with channel 1 also requesting
        push_block_a(0, 32'h44332211);
        req_a = 4'b0011;
        wait_ack_a("t5_restart", 20);
        drain_a("t5_restart", 100);

        // 6: request pulse while another channel is busy is ignored
        set_block_a(3, blk_val(3));
        push_block_a(3, blk_val(3));
        req_a = 4'b1000;
        wait_ack_a("t6", 20);
        repeat (2) @(posedge clk);
        #1;
        req_a = 4'b0010;
        @(posedge clk); #1;
        req_a = 4'b0000;
        drain_a("t6", 100);
        repeat (20) @(posedge clk);
        #1;
        check("t6_no_grant_busy", 32'(busy_a), 0);
        check("t6_no_grant_ack", 32'(ack_a), 0);
        check("t6_queues_empty", 32'(exp_q_a.size() + exp_gnt_a.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
